// File: rtl/count_monitor.sv
// Passive checker for a free-running counter bus: confirms q_in steps by +1 mod 2^WIDTH
// each clock, declares lock after a run of good samples, and counts errors and wraps.
module count_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8,
  parameter int WRAP_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              cnt_rst,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  expected
);

  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [MW-1:0]     match_q, match_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic [WIDTH-1:0]  expected_q, expected_d;
  logic              hit;

  assign hit = (q_in == expected_q);

  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    expected_d   = q_in + WIDTH'(1);

    if (cnt_rst) begin
      // Counter is being reset: park without comparing so no false error is raised.
      state_d  = HOLD;
      match_d  = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          state_d  = ACQUIRE;
          match_d  = '0;
          locked_d = 1'b0;
        end
        ACQUIRE: begin
          if (hit) begin
            if (match_q == MATCH_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              match_d  = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            if ((q_in == '0) && (wrap_count_q != '1))
              wrap_count_d = wrap_count_q + WRAP_W'(1);
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1)
              err_count_d = err_count_q + ERR_W'(1);
            locked_d = 1'b0;
            state_d  = ACQUIRE;
            match_d  = '0;
          end
        end
        default: begin
          state_d  = IDLE;
          match_d  = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      match_q      <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      expected_q   <= '0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      expected_q   <= expected_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign expected   = expected_q;

endmodule

// File: doc/count_monitor.md
# count_monitor

- Passive sequence checker that sits on the output bus of the ripple-carry counter and consumes the `q` stream.
- Verifies that `q` advances by exactly +1 modulo 2^WIDTH per `clk` cycle, and reports lock status, errors and wrap events.
- Used by benches and on-chip self-test. It never drives the counter.

## Interface
Parameters:
- `WIDTH`, 4, width of the monitored count.
- `LOCK_COUNT`, 4, consecutive correct samples required to declare lock (≥1).
- `ERR_W`, 8, width of the error counter.
- `WRAP_W`, 8, width of the wrap counter.

Ports:
- `clk`  in  1  clock. Counter value is sampled on posedge.
- `reset`  in  1  synchronous, active-high monitor reset.
- `q_in`  in  WIDTH  observed counter value.
- `cnt_rst`  in  1  copy of the counter's reset. While high, checking is suspended.
- `locked`  out  1  high while in LOCKED.
- `err_pulse`  out  1  one-cycle pulse on a mismatch detected while locked.
- `err_count`  out  ERR_W  total mismatches while locked; saturating.
- `wrap_count`  out  WRAP_W  number of correct (2^WIDTH−1)→0 transitions while locked; saturating.
- `expected`  out  WIDTH  value predicted for the next sample (debug).

## Operation
General rules:
- All outputs are registered and update on the same `clk` edge that samples `q_in`.
- Internal state: `state` (IDLE, ACQUIRE, LOCKED, HOLD) and `match` (counts 0..LOCK_COUNT−1).
- `expected` is always `q_in + 1` truncated to WIDTH bits, so 2^WIDTH−1 wraps to 0.

Priority, highest first:
1. `reset`: all outputs 0, `match` 0, state IDLE.
2. `cnt_rst` high: state HOLD, `match` 0, `locked` 0. No compare, no counter update.
3. State transitions below.

State transitions:
- **IDLE:** load `expected`; go to ACQUIRE with `match`=0. No compare.
- **HOLD:** on `cnt_rst` low, behave exactly as IDLE (load `expected`, go to ACQUIRE). Checking restarts from the first post-reset sample.
- **ACQUIRE, `q_in`==`expected`:**
  - If `match`==LOCK_COUNT−1, go to LOCKED and set `locked`=1.
  - Otherwise increment `match`.
  - Load `expected` in both cases.
- **ACQUIRE, mismatch:** `match`=0, load `expected`. No error is reported.
- **LOCKED, `q_in`==`expected`:** load `expected`. If `q_in`==0, increment `wrap_count`.
- **LOCKED, mismatch:**
  - `err_pulse`=1 for exactly this one update.
  - Increment `err_count`.
  - `locked`=0, go to ACQUIRE with `match`=0, load `expected` from the bad sample.
- `err_pulse` is 0 on every other update.
- Wraps seen during ACQUIRE are not counted.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, `wrap_count`=0, `expected`=0, state IDLE.
- Lock latency: from the first sample after IDLE/HOLD, `locked` rises after LOCK_COUNT+1 samples, i.e. 1 load sample plus LOCK_COUNT matches.
- Error latency: `err_pulse` is high for the single cycle following the edge that sampled the bad value. `err_count` updates on that same edge.
- Saturation: `err_count` holds at 2^ERR_W−1 and `wrap_count` holds at 2^WRAP_W−1. `err_pulse` still fires at saturation.
- `cnt_rst` and a mismatch in the same cycle: HOLD wins; no error is reported.
- `reset` asserted mid-LOCKED: all outputs return to reset values on that edge.
- LOCK_COUNT=1: lock is declared on the first match after the load sample.

## Test plan
Default parameters unless noted.
1. **Lock-in from reset.** Release `reset` and `cnt_rst`; counter runs 0,1,2,…
   - `locked`=1 after the edge sampling q=4.
   - `expected`=5.
   - `err_count`=0.
2. **Wrap.** Continue from scenario 1 through 15→0.
   - `wrap_count`=1 after sampling 0.
   - `wrap_count`=2 after the next 15→0.
   - No `err_pulse`.
3. **Injected error.** While locked with `expected`=7, force `q_in`=9 for one cycle, then continue 10,11,12,13.
   - `err_pulse` high for exactly one cycle; `err_count`=1; `locked`=0.
   - `locked`=1 again after the sample of 13.
4. **Counter reset.** Pulse `cnt_rst` for 1 cycle while locked at q=6; counter restarts from 0.
   - No `err_pulse`; `locked`=0 during HOLD.
   - Relock after samples 0,1,2,3,4.
   - `err_count` unchanged.
5. **Saturation.** With ERR_W=2, inject 5 separate errors, each followed by relock.
   - `err_count` sequence is 1,2,3,3,3.
   - `err_pulse` fires 5 times.
6. **Monitor reset mid-lock.** Assert `reset` for 1 cycle while locked with `wrap_count`=2.
   - All outputs are 0 on the next cycle.
   - Relock follows the scenario 1 timing.
